// File: rtl/rr_stream_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb_pkg
//  Purpose  : Shared types and helpers for the round-robin stream arbiter.
//             onehot()  : index -> one-hot vector (bits at or above n cleared)
//             rr_pick() : rotate-priority search starting just above ptr
//  Notes    : Helpers work on a fixed RR_MAX_CH-wide request vector. Callers
//             zero-extend narrower vectors. Because the unused upper bits are
//             zero, a search that wraps modulo RR_MAX_CH gives the same winner
//             as a search that wraps modulo the real channel count.
//  Revision : 1.0 - initial release
// ============================================================================
package rr_arb_pkg;

    localparam int RR_MAX_CH = 64;              // largest supported channel count
    localparam int RR_IDX_W  = $clog2(RR_MAX_CH);

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    function automatic logic [RR_MAX_CH-1:0] onehot(input logic [RR_IDX_W-1:0] idx,
                                                    input int unsigned         n);
        logic [RR_MAX_CH-1:0] v;
        v = '0;
        if (32'(idx) < n) begin
            v[idx] = 1'b1;
        end
        return v;
    endfunction

    // First set bit of req at ptr+1, ptr+2, ... wrapping, with ptr itself last.
    // Walking downward and overwriting leaves the closest candidate as the winner.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_CH-1:0] req,
                                         input logic [RR_IDX_W-1:0]  ptr);
        rr_pick_t            r;
        logic [RR_IDX_W-1:0] cand;
        r = '0;
        for (int i = RR_MAX_CH; i >= 1; i--) begin
            cand = ptr + RR_IDX_W'(i);
            if (req[cand]) begin
                r.found = 1'b1;
                r.idx   = cand;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_stream_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : rr_stream_arbiter_if
//  Purpose  : Bundles the upstream channels and the downstream stream of the
//             round-robin arbiter.
//  Signals  : t_data_i/t_valid_i/t_last_i/t_ready_o  - T_AMOUNT upstream channels
//             t_data_o/t_valid_o/t_last_o/t_ready_i  - merged downstream stream
//             t_number_o                             - one-hot source of output beat
//  Modports : slave  - the arbiter
//             master - the environment (sources and sink) around it
//  Revision : 1.0 - initial release
// ============================================================================
interface rr_stream_arbiter_if #(
    parameter int BIT_DEPTH = 8,
    parameter int T_AMOUNT  = 4
);
    logic [BIT_DEPTH-1:0] t_data_i [T_AMOUNT];
    logic [T_AMOUNT-1:0]  t_valid_i;
    logic [T_AMOUNT-1:0]  t_last_i;
    logic [T_AMOUNT-1:0]  t_ready_o;
    logic [BIT_DEPTH-1:0] t_data_o;
    logic                 t_valid_o;
    logic                 t_last_o;
    logic                 t_ready_i;
    logic [T_AMOUNT-1:0]  t_number_o;

    modport slave (
        input  t_data_i, t_valid_i, t_last_i, t_ready_i,
        output t_ready_o, t_data_o, t_valid_o, t_last_o, t_number_o
    );

    modport master (
        output t_data_i, t_valid_i, t_last_i, t_ready_i,
        input  t_ready_o, t_data_o, t_valid_o, t_last_o, t_number_o
    );
endinterface
`default_nettype wire

// File: rtl/rr_grant_picker.sv
`default_nettype none
// ============================================================================
//  Module   : rr_grant_picker
//  Purpose  : Combinational rotate-priority encoder. Finds the first request
//             after ptr, wrapping, with ptr itself having the lowest priority.
//  Ports    : req   in  T_AMOUNT  request vector
//             ptr   in  PTR_W     last granted index
//             found out 1         some request is set
//             grant out PTR_W     winning index (valid when found)
//  Limits   : T_AMOUNT in 2..RR_MAX_CH
//  Revision : 1.0 - initial release
// ============================================================================
module rr_grant_picker
    import rr_arb_pkg::*;
#(
    parameter  int T_AMOUNT = 4,
    localparam int PTR_W    = $clog2(T_AMOUNT)
) (
    input  wire logic [T_AMOUNT-1:0] req,
    input  wire logic [PTR_W-1:0]    ptr,
    output logic                     found,
    output logic [PTR_W-1:0]         grant
);
    rr_pick_t pick;
    logic     unused_pick_idx;

    assign pick  = rr_pick(RR_MAX_CH'(req), RR_IDX_W'(ptr));
    assign found = pick.found;
    assign grant = pick.idx[PTR_W-1:0];

    // Upper index bits are always zero since req is zero-extended.
    assign unused_pick_idx = ^pick.idx;

endmodule
`default_nettype wire

// File: rtl/rr_stream_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_stream_arbiter
//  Purpose  : N-channel round-robin stream arbiter with a registered output
//             stage. Throughput is one beat per cycle, and each beat reports
//             its source channel as one-hot.
//  Ports    : clk    in  clock, rising edge
//             arstn  in  asynchronous active-low reset (synchronous release)
//             bus    slave modport of rr_stream_arbiter_if
//  Options  : RR_ARB_PKT_LOCK_EN - when defined, a granted channel keeps the
//             output until it sends a beat with t_last_i set.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_stream_arbiter
    import rr_arb_pkg::*;
#(
    parameter int BIT_DEPTH = 8,
    parameter int T_AMOUNT  = 4
) (
    input wire logic          clk,
    input wire logic          arstn,
    rr_stream_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(T_AMOUNT);

    logic [BIT_DEPTH-1:0] t_data_o_q,   t_data_o_d;
    logic                 t_valid_o_q,  t_valid_o_d;
    logic                 t_last_o_q,   t_last_o_d;
    logic [T_AMOUNT-1:0]  t_number_o_q, t_number_o_d;
    logic [PTR_W-1:0]     ptr_q,        ptr_d;
`ifdef RR_ARB_PKT_LOCK_EN
    logic                 lock_q,       lock_d;
`endif

    logic                 load_en;
    logic                 pick_found;
    logic [PTR_W-1:0]     pick_grant;
    logic                 grant_found;
    logic [PTR_W-1:0]     grant;
    logic [RR_MAX_CH-1:0] grant_oh;
    logic                 xfer;
    logic                 unused_grant_oh;

    rr_grant_picker #(
        .T_AMOUNT (T_AMOUNT)
    ) u_picker (
        .req   (bus.t_valid_i),
        .ptr   (ptr_q),
        .found (pick_found),
        .grant (pick_grant)
    );

    // While a packet is open, the locked channel owns the output and the
    // rotation is bypassed. A locked channel with no valid data gives a bubble.
    always_comb begin
        grant       = pick_grant;
        grant_found = pick_found;
`ifdef RR_ARB_PKT_LOCK_EN
        if (lock_q) begin
            grant       = ptr_q;
            grant_found = bus.t_valid_i[ptr_q];
        end
`endif
    end

    // The output register can take a new beat when it is empty or draining.
    assign load_en  = !t_valid_o_q || bus.t_ready_i;
    assign grant_oh = onehot(RR_IDX_W'(grant), T_AMOUNT);
    // arstn gating keeps sources from handing off beats that reset would drop.
    assign xfer     = load_en && grant_found && arstn;
    assign unused_grant_oh = ^grant_oh;

    // Next-state logic
    always_comb begin
        t_data_o_d   = t_data_o_q;
        t_valid_o_d  = t_valid_o_q;
        t_last_o_d   = t_last_o_q;
        t_number_o_d = t_number_o_q;
        ptr_d        = ptr_q;
`ifdef RR_ARB_PKT_LOCK_EN
        lock_d       = lock_q;
`endif
        if (load_en) begin
            if (grant_found) begin
                t_data_o_d   = bus.t_data_i[grant];
                t_last_o_d   = bus.t_last_i[grant];
                t_number_o_d = grant_oh[T_AMOUNT-1:0];
                t_valid_o_d  = 1'b1;
                ptr_d        = grant;
`ifdef RR_ARB_PKT_LOCK_EN
                lock_d       = !bus.t_last_i[grant];
`endif
            end else begin
                t_valid_o_d  = 1'b0;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            t_data_o_q   <= '0;
            t_valid_o_q  <= 1'b0;
            t_last_o_q   <= 1'b0;
            t_number_o_q <= '0;
            ptr_q        <= PTR_W'(T_AMOUNT - 1);
`ifdef RR_ARB_PKT_LOCK_EN
            lock_q       <= 1'b0;
`endif
        end else begin
            t_data_o_q   <= t_data_o_d;
            t_valid_o_q  <= t_valid_o_d;
            t_last_o_q   <= t_last_o_d;
            t_number_o_q <= t_number_o_d;
            ptr_q        <= ptr_d;
`ifdef RR_ARB_PKT_LOCK_EN
            lock_q       <= lock_d;
`endif
        end
    end

    // Outputs
    assign bus.t_ready_o  = xfer ? grant_oh[T_AMOUNT-1:0] : '0;
    assign bus.t_data_o   = t_data_o_q;
    assign bus.t_valid_o  = t_valid_o_q;
    assign bus.t_last_o   = t_last_o_q;
    assign bus.t_number_o = t_number_o_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_stream_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_stream_arbiter
//  Purpose  : Self-checking bench for rr_stream_arbiter (BIT_DEPTH=8,
//             T_AMOUNT=4): directed scenarios followed by random traffic,
//             all checked against a channel-level reference model.
//  Options  : honours RR_ARB_PKT_LOCK_EN in the reference model
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rr_stream_arbiter;
    localparam int BD = 8;
    localparam int N  = 4;

    logic clk;
    logic arstn;
    int   checks   = 0;
    int   failures = 0;

    rr_stream_arbiter_if #(.BIT_DEPTH(BD), .T_AMOUNT(N)) bus ();

    rr_stream_arbiter #(.BIT_DEPTH(BD), .T_AMOUNT(N)) dut (
        .clk   (clk),
        .arstn (arstn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (channel level) ----------------
    int          m_last_ch;   // channel that won most recently
    bit          m_valid;
    logic [BD-1:0] m_data;
    logic [N-1:0]  m_num;
    bit          m_last;
    bit          m_lock;
    int          m_g;         // channel granted in the latest step, -1 if none

    task automatic model_reset();
        m_last_ch = N - 1;
        m_valid   = 0;
        m_data    = '0;
        m_num     = '0;
        m_last    = 0;
        m_lock    = 0;
    endtask

    function automatic int model_grant();
        if (!arstn) return -1;
        if (m_valid && !bus.t_ready_i) return -1;
`ifdef RR_ARB_PKT_LOCK_EN
        if (m_lock) return bus.t_valid_i[m_last_ch] ? m_last_ch : -1;
`endif
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last_ch + k) % N;
            if (bus.t_valid_i[c]) return c;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check everything against the model, then advance both.
    task automatic step();
        int g;
        #1;
        g = model_grant();
        chk("t_ready_o",  32'(bus.t_ready_o),  (g < 0) ? 32'd0 : (32'd1 << g));
        chk("t_valid_o",  32'(bus.t_valid_o),  32'(m_valid));
        chk("t_data_o",   32'(bus.t_data_o),   32'(m_data));
        chk("t_number_o", 32'(bus.t_number_o), 32'(m_num));
        chk("t_last_o",   32'(bus.t_last_o),   32'(m_last));
        if (arstn && (!m_valid || bus.t_ready_i)) begin
            if (g >= 0) begin
                m_valid   = 1;
                m_data    = bus.t_data_i[g];
                m_num     = N'(1 << g);
                m_last    = bus.t_last_i[g];
                m_last_ch = g;
                m_lock    = !bus.t_last_i[g];
            end else begin
                m_valid = 0;
            end
        end
        m_g = g;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_default_data();
        for (int c = 0; c < N; c++) bus.t_data_i[c] = BD'(8'hA0 + c);
    endtask

    initial begin : stim
        logic [N-1:0]  exp_num2 [5];
        logic [BD-1:0] exp_dat2 [5];
        logic [N-1:0]  exp_num5 [3];
        logic [N-1:0]  exp_num6 [4];
        logic [BD-1:0] held;
        int            beats0;

        exp_num2 = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        exp_dat2 = '{8'hA1, 8'hA2, 8'hA3, 8'hA0, 8'hA1};
        exp_num5 = '{4'b0010, 4'b1000, 4'b0010};
`ifdef RR_ARB_PKT_LOCK_EN
        exp_num6 = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
`else
        exp_num6 = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
`endif

        // 1: reset held with every channel valid, then release
        arstn         = 1'b1;
        set_default_data();
        bus.t_valid_i = '1;
        bus.t_last_i  = '1;
        bus.t_ready_i = 1'b1;
        model_reset();
        #2 arstn = 1'b0;
        @(negedge clk);
        step();
        step();
        arstn = 1'b1;
        step();
        chk("t1_num", 32'(bus.t_number_o), 32'h1);
        chk("t1_dat", 32'(bus.t_data_o),   32'hA0);

        // 2: full rotation, one beat per cycle
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_num", 32'(bus.t_number_o), 32'(exp_num2[i]));
            chk("t2_dat", 32'(bus.t_data_o),   32'(exp_dat2[i]));
            chk("t2_val", 32'(bus.t_valid_o),  32'h1);
        end

        // 3: single active channel granted back to back
        bus.t_valid_i = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            bus.t_data_i[2] = BD'(8'h20 + i);
            step();
            chk("t3_num", 32'(bus.t_number_o), 32'h4);
            chk("t3_dat", 32'(bus.t_data_o),   32'(8'h20 + i));
            chk("t3_val", 32'(bus.t_valid_o),  32'h1);
        end

        // 4: downstream stall holds the output and withdraws every ready
        set_default_data();
        bus.t_valid_i = '1;
        bus.t_ready_i = 1'b0;
        held          = 8'h24;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_hold_dat", 32'(bus.t_data_o),   32'(held));
            chk("t4_hold_num", 32'(bus.t_number_o), 32'h4);
        end
        #1 chk("t4_rdy_stall", 32'(bus.t_ready_o), 32'h0);
        bus.t_ready_i = 1'b1;
        step();
        chk("t4_next_num", 32'(bus.t_number_o), 32'h8);

        // 5: sparse requesters wrap from the top channel
        bus.t_valid_i = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_num", 32'(bus.t_number_o), 32'(exp_num5[i]));
        end

        // 6: 3-beat packet on channel 0 with channel 1 competing
        bus.t_valid_i = 4'b1000;
        step();                         // pointer now on channel 3
        beats0        = 0;
        bus.t_valid_i = 4'b0011;
        bus.t_last_i  = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t6_num", 32'(bus.t_number_o), 32'(exp_num6[i]));
            if (m_g == 0) beats0++;
            bus.t_last_i[0] = (beats0 == 2);
            if (beats0 == 3) bus.t_valid_i[0] = 1'b0;
        end

        // 7: random traffic, with one reset in the middle of a transfer
        for (int i = 0; i < 400; i++) begin
            bus.t_valid_i = N'($urandom);
            bus.t_last_i  = N'($urandom);
            bus.t_ready_i = ($urandom_range(0, 9) < 7);
            for (int c = 0; c < N; c++) bus.t_data_i[c] = BD'($urandom);
            if (i == 200) begin
                #3 arstn = 1'b0;
                model_reset();
                #1;
                chk("rst_async_val", 32'(bus.t_valid_o),  32'h0);
                chk("rst_async_num", 32'(bus.t_number_o), 32'h0);
                @(negedge clk);
                step();
                arstn = 1'b1;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
